// File: rtl/alu_packet_parser.sv
// rtl/alu_packet_parser.sv - header decoder and payload splitter for the UART ALU byte stream
module alu_packet_parser #(
    parameter logic [7:0] OPCODE_ECHO = 8'hEC,
    parameter logic [7:0] OPCODE_ADD  = 8'hAD,
    parameter logic [7:0] OPCODE_MUL  = 8'h88,
    parameter logic [7:0] OPCODE_DIV  = 8'hD1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        hdr_valid_o,
    output logic [7:0]  opcode_o,
    output logic [15:0] length_o,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        last_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_RESERVED,
        ST_LEN_LSB,
        ST_LEN_MSB,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    state_t      state_q;
    logic [7:0]  op_q;
    logic [7:0]  len_lsb_q;
    logic [15:0] count_q;
    logic        echo_q;
    logic [1:0]  idx_q;
    logic [23:0] asm_q;
    logic        byte_last_q;
    logic        word_last_q;

    logic [15:0] len_w;
    logic [15:0] rem_w;
    logic        len_short;
    logic        op_arith;
    logic        op_known;
    logic        arith_bad;
    logic        last_in;
    logic        rx_fire;

    always_comb begin
        len_w     = {rx_data_i, len_lsb_q};
        len_short = len_w < 16'd4;
        // Remaining count saturates at zero so a short length never wraps.
        rem_w     = len_short ? 16'd0 : len_w - 16'd4;
        op_arith  = (op_q == OPCODE_ADD) || (op_q == OPCODE_MUL) || (op_q == OPCODE_DIV);
        op_known  = op_arith || (op_q == OPCODE_ECHO);
        arith_bad = op_arith && ((rem_w[1:0] != 2'd0) || (rem_w < 16'd8));
        last_in   = count_q == 16'd1;

        rx_ready_o = 1'b1;
        if (state_q == ST_PAYLOAD) begin
            if (echo_q) begin
                rx_ready_o = !byte_valid_o || byte_ready_i;
            end else begin
                // Only the word-completing byte needs room in the output register.
                rx_ready_o = !((idx_q == 2'd3) && word_valid_o && !word_ready_i);
            end
        end
    end

    assign rx_fire = rx_valid_i && rx_ready_o;
    assign last_o  = (byte_valid_o && byte_last_q) || (word_valid_o && word_last_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_OPCODE;
            op_q         <= 8'd0;
            len_lsb_q    <= 8'd0;
            count_q      <= 16'd0;
            echo_q       <= 1'b0;
            idx_q        <= 2'd0;
            asm_q        <= 24'd0;
            byte_last_q  <= 1'b0;
            word_last_q  <= 1'b0;
            hdr_valid_o  <= 1'b0;
            err_o        <= 1'b0;
            opcode_o     <= 8'd0;
            length_o     <= 16'd0;
            byte_o       <= 8'd0;
            byte_valid_o <= 1'b0;
            word_o       <= 32'd0;
            word_valid_o <= 1'b0;
        end else begin
            hdr_valid_o <= 1'b0;
            err_o       <= 1'b0;

            // Output registers drain in any state; a load below overrides the drain.
            if (byte_valid_o && byte_ready_i) begin
                byte_valid_o <= 1'b0;
            end
            if (word_valid_o && word_ready_i) begin
                word_valid_o <= 1'b0;
            end

            if (rx_fire) begin
                case (state_q)
                    ST_OPCODE: begin
                        op_q    <= rx_data_i;
                        state_q <= ST_RESERVED;
                    end
                    ST_RESERVED: begin
                        state_q <= ST_LEN_LSB;
                    end
                    ST_LEN_LSB: begin
                        len_lsb_q <= rx_data_i;
                        state_q   <= ST_LEN_MSB;
                    end
                    ST_LEN_MSB: begin
                        count_q <= rem_w;
                        idx_q   <= 2'd0;
                        echo_q  <= (op_q == OPCODE_ECHO);
                        if (!op_known || len_short || arith_bad) begin
                            err_o   <= 1'b1;
                            state_q <= (rem_w == 16'd0) ? ST_OPCODE : ST_DROP;
                        end else begin
                            hdr_valid_o <= 1'b1;
                            opcode_o    <= op_q;
                            length_o    <= len_w;
                            state_q     <= (rem_w == 16'd0) ? ST_OPCODE : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        count_q <= count_q - 16'd1;
                        if (last_in) begin
                            state_q <= ST_OPCODE;
                        end
                        if (echo_q) begin
                            byte_o       <= rx_data_i;
                            byte_valid_o <= 1'b1;
                            byte_last_q  <= last_in;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                            case (idx_q)
                                2'd0: asm_q[7:0]   <= rx_data_i;
                                2'd1: asm_q[15:8]  <= rx_data_i;
                                2'd2: asm_q[23:16] <= rx_data_i;
                                default: begin
                                    word_o       <= {rx_data_i, asm_q};
                                    word_valid_o <= 1'b1;
                                    word_last_q  <= last_in;
                                end
                            endcase
                        end
                    end
                    ST_DROP: begin
                        count_q <= count_q - 16'd1;
                        if (last_in) begin
                            state_q <= ST_OPCODE;
                        end
                    end
                    default: begin
                        state_q <= ST_OPCODE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_packet_parser.sv
// tb/tb_alu_packet_parser.sv - directed self-checking bench for alu_packet_parser
module tb_alu_packet_parser;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        hdr_valid_o;
    logic [7:0]  opcode_o;
    logic [15:0] length_o;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic        last_o;
    logic        err_o;

    int n_total = 0;
    int n_bad   = 0;
    int wmode   = 1;
    int err_cnt = 0;

    logic [8:0]  byte_q[$];
    logic [32:0] word_q[$];
    logic [23:0] hdr_q[$];

    logic        hold_pend = 1'b0;
    logic [31:0] hold_word = 32'd0;

    int b0, w0, h0, e0;

    always #5 clk_i = ~clk_i;

    alu_packet_parser dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .hdr_valid_o  (hdr_valid_o),
        .opcode_o     (opcode_o),
        .length_o     (length_o),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .last_o       (last_o),
        .err_o        (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 0: ready low, 1: ready high, 2: toggle every cycle
    initial begin
        word_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (wmode == 2) word_ready_i = ~word_ready_i;
            else            word_ready_i = (wmode == 1);
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (hold_pend && rst_ni) begin
                chk("word_hold_valid", {31'd0, word_valid_o}, 32'd1);
                chk("word_hold_data", word_o, hold_word);
            end
            hold_pend = word_valid_o && !word_ready_i;
            hold_word = word_o;
            if (byte_valid_o && byte_ready_i) byte_q.push_back({last_o, byte_o});
            if (word_valid_o && word_ready_i) word_q.push_back({last_o, word_o});
            if (hdr_valid_o) hdr_q.push_back({opcode_o, length_o});
            if (err_o) err_cnt++;
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (rx_ready_o) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", {31'd0, rx_ready_o}, 32'd1);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic mark();
        b0 = byte_q.size();
        w0 = word_q.size();
        h0 = hdr_q.size();
        e0 = err_cnt;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready_o}, 32'd1);
        chk({tag, "_hdr_valid"}, {31'd0, hdr_valid_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
        chk({tag, "_byte_valid"}, {31'd0, byte_valid_o}, 32'd0);
        chk({tag, "_word_valid"}, {31'd0, word_valid_o}, 32'd0);
        chk({tag, "_last"}, {31'd0, last_o}, 32'd0);
        chk({tag, "_opcode"}, {24'd0, opcode_o}, 32'd0);
        chk({tag, "_length"}, {16'd0, length_o}, 32'd0);
        chk({tag, "_byte"}, {24'd0, byte_o}, 32'd0);
        chk({tag, "_word"}, word_o, 32'd0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        rx_data_i    = 8'd0;
        rx_valid_i   = 1'b0;
        byte_ready_i = 1'b1;
        idle(3);
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        idle(2);

        // ECHO length 7
        mark();
        send4(8'hEC, 8'h00, 8'h07, 8'h00);
        send(8'h41); send(8'h42); send(8'h43);
        idle(4);
        chk("echo_hdr_n", hdr_q.size() - h0, 1);
        chk("echo_hdr", {8'd0, hdr_q[h0]}, {8'd0, 8'hEC, 16'd7});
        chk("echo_nbytes", byte_q.size() - b0, 3);
        chk("echo_b0", {23'd0, byte_q[b0]}, {23'd0, 1'b0, 8'h41});
        chk("echo_b1", {23'd0, byte_q[b0+1]}, {23'd0, 1'b0, 8'h42});
        chk("echo_b2", {23'd0, byte_q[b0+2]}, {23'd0, 1'b1, 8'h43});
        chk("echo_err", err_cnt - e0, 0);

        // ADD length 12 with toggling word_ready
        mark();
        wmode = 2;
        send4(8'hAD, 8'h00, 8'h0C, 8'h00);
        send4(8'h01, 8'h00, 8'h00, 8'h00);
        send4(8'h02, 8'h00, 8'h00, 8'h00);
        idle(8);
        wmode = 1;
        idle(2);
        chk("add_hdr", {8'd0, hdr_q[h0]}, {8'd0, 8'hAD, 16'd12});
        chk("add_nwords", word_q.size() - w0, 2);
        chk("add_w0", word_q[w0][31:0], 32'h0000_0001);
        chk("add_w0_last", {31'd0, word_q[w0][32]}, 32'd0);
        chk("add_w1", word_q[w0+1][31:0], 32'h0000_0002);
        chk("add_w1_last", {31'd0, word_q[w0+1][32]}, 32'd1);

        // unknown opcode, then ECHO length 4 with no payload
        mark();
        send4(8'h55, 8'h00, 8'h06, 8'h00);
        send(8'hAA); send(8'hBB);
        send4(8'hEC, 8'h00, 8'h04, 8'h00);
        idle(4);
        chk("unk_err", err_cnt - e0, 1);
        chk("unk_hdr_n", hdr_q.size() - h0, 1);
        chk("unk_hdr", {8'd0, hdr_q[h0]}, {8'd0, 8'hEC, 16'd4});
        chk("unk_nbytes", byte_q.size() - b0, 0);
        chk("unk_nwords", word_q.size() - w0, 0);

        // length below header size: error, no drop phase
        mark();
        send4(8'hEC, 8'h00, 8'h02, 8'h00);
        send4(8'hEC, 8'h00, 8'h04, 8'h00);
        idle(4);
        chk("short_err", err_cnt - e0, 1);
        chk("short_hdr", {8'd0, hdr_q[h0]}, {8'd0, 8'hEC, 16'd4});
        chk("short_hdr_n", hdr_q.size() - h0, 1);

        // MUL length 10 is misaligned: 6 bytes dropped
        mark();
        send4(8'h88, 8'h00, 8'h0A, 8'h00);
        repeat (6) send(8'h33);
        send4(8'hEC, 8'h00, 8'h05, 8'h00);
        send(8'h99);
        idle(4);
        chk("mul_err", err_cnt - e0, 1);
        chk("mul_hdr_n", hdr_q.size() - h0, 1);
        chk("mul_hdr", {8'd0, hdr_q[h0]}, {8'd0, 8'hEC, 16'd5});
        chk("mul_nbytes", byte_q.size() - b0, 1);
        chk("mul_b0", {23'd0, byte_q[b0]}, {23'd0, 1'b1, 8'h99});
        chk("mul_nwords", word_q.size() - w0, 0);

        // DIV length 12 with word_ready held low: backpressure on 8th byte
        mark();
        wmode = 0;
        idle(1);
        send4(8'hD1, 8'h00, 8'h0C, 8'h00);
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        send(8'h55); send(8'h66); send(8'h77);
        rx_data_i  = 8'h88;
        rx_valid_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("div_rx_ready", {31'd0, rx_ready_o}, 32'd0);
        chk("div_wvalid", {31'd0, word_valid_o}, 32'd1);
        chk("div_word_held", word_o, 32'h4433_2211);
        chk("div_nwords_stall", word_q.size() - w0, 0);
        wmode = 1;
        send(8'h88);
        idle(4);
        chk("div_hdr", {8'd0, hdr_q[h0]}, {8'd0, 8'hD1, 16'd12});
        chk("div_nwords", word_q.size() - w0, 2);
        chk("div_w0", word_q[w0][31:0], 32'h4433_2211);
        chk("div_w0_last", {31'd0, word_q[w0][32]}, 32'd0);
        chk("div_w1", word_q[w0+1][31:0], 32'h8877_6655);
        chk("div_w1_last", {31'd0, word_q[w0+1][32]}, 32'd1);

        // reset after two ADD payload bytes
        send4(8'hAD, 8'h00, 8'h0C, 8'h00);
        send(8'h01); send(8'h02);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(1);
        mark();
        send4(8'hEC, 8'h00, 8'h05, 8'h00);
        send(8'h5A);
        send4(8'hAD, 8'h00, 8'h0C, 8'h00);
        send4(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        send4(8'h01, 8'h02, 8'h03, 8'h04);
        idle(4);
        chk("post_rst_err", err_cnt - e0, 0);
        chk("post_rst_hdr_n", hdr_q.size() - h0, 2);
        chk("post_rst_hdr0", {8'd0, hdr_q[h0]}, {8'd0, 8'hEC, 16'd5});
        chk("post_rst_hdr1", {8'd0, hdr_q[h0+1]}, {8'd0, 8'hAD, 16'd12});
        chk("post_rst_b0", {23'd0, byte_q[b0]}, {23'd0, 1'b1, 8'h5A});
        chk("post_rst_nwords", word_q.size() - w0, 2);
        chk("post_rst_w0", word_q[w0][31:0], 32'h0D0C_0B0A);
        chk("post_rst_w1", word_q[w0+1][31:0], 32'h0403_0201);
        chk("post_rst_w1_last", {31'd0, word_q[w0+1][32]}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_packet_parser.md
# alu_packet_parser

Front-end packet parser for the UART ALU. It consumes the byte stream from the UART receiver and decodes the 4-byte header: opcode, reserved, length LSB, length MSB. It then delivers the payload downstream: ECHO payload as bytes, ADD/MUL/DIV payload as 32-bit little-endian operand words. It sits between `uart_rx` and the ALU controller/arithmetic units and screens malformed packets so that downstream never sees them.

## Interface
Parameters:
- `OPCODE_ECHO`, default 8'hEC: echo opcode
- `OPCODE_ADD`, default 8'hAD: add opcode
- `OPCODE_MUL`, default 8'h88: multiply opcode
- `OPCODE_DIV`, default 8'hD1: divide opcode

Ports:
- `clk_i`  in  1  clock (single clock domain)
- `rst_ni`  in  1  asynchronous, active-low reset
- `rx_data_i`  in  8  received byte
- `rx_valid_i`  in  1  byte valid
- `rx_ready_o`  out  1  parser accepts byte; transfer when valid&ready
- `hdr_valid_o`  out  1  1-cycle pulse: header accepted, `opcode_o`/`length_o` valid
- `opcode_o`  out  8  latched opcode, held until next header
- `length_o`  out  16  latched total packet length, header included
- `byte_o`  out  8  ECHO payload byte
- `byte_valid_o`  out  1  ECHO byte valid
- `byte_ready_i`  in  1  downstream accepts byte
- `word_o`  out  32  arithmetic operand; first received byte is bits [7:0]
- `word_valid_o`  out  1  operand valid
- `word_ready_i`  in  1  downstream accepts operand
- `last_o`  out  1  qualifies the final byte or word of the packet
- `err_o`  out  1  1-cycle pulse on malformed packet

## Operation
- States: OPCODE, RESERVED, LEN_LSB, LEN_MSB, PAYLOAD, DROP.
- In OPCODE, RESERVED, LEN_LSB, LEN_MSB and DROP, `rx_ready_o` = 1.
- OPCODE → RESERVED on any accepted byte; the byte is latched into an internal opcode register. The reserved byte is ignored.
- LEN_LSB latches `length[7:0]`; LEN_MSB latches `length[15:8]`. Remaining count = length − 4.
- Decision on the LEN_MSB byte:
  - opcode unknown, or length < 4: pulse `err_o`, go to DROP with count = max(length − 4, 0); if count is 0, go to OPCODE.
  - ADD/MUL/DIV with (length − 4) not a multiple of 4, or length − 4 < 8: pulse `err_o`, go to DROP.
  - otherwise: publish `opcode_o`/`length_o`, pulse `hdr_valid_o`, then:
    - count 0 (ECHO only) → OPCODE, no payload;
    - count > 0 → PAYLOAD.
- PAYLOAD, ECHO:
  - One-entry byte output register.
  - `rx_ready_o` = !`byte_valid_o` | `byte_ready_i` (pass-through when drained same cycle).
  - Each accepted byte loads `byte_o` and decrements the count.
  - `last_o` is set with the byte that makes the count 0; the FSM then goes to OPCODE.
- PAYLOAD, ADD/MUL/DIV:
  - Bytes shift into a 2-bit-indexed assembly buffer.
  - On the 4th byte the assembled word loads the word output register.
  - `rx_ready_o` = 0 while the 4th byte is pending and the output register is full and not being drained.
  - `last_o` accompanies the word that completes the payload; the FSM then goes to OPCODE.
- DROP: consume and discard count bytes, then OPCODE. No output valids.
- The output register of the final item may still be held in OPCODE; the next header proceeds regardless (the register is independent).

## Timing
- Reset values:
  - all valids, `hdr_valid_o`, `err_o`, `last_o` = 0;
  - `opcode_o` = 0, `length_o` = 0, `byte_o` = 0, `word_o` = 0;
  - state OPCODE, count 0, `rx_ready_o` = 1 (combinational from state).
- `hdr_valid_o`/`err_o` assert in the cycle after the LEN_MSB byte handshake.
- Byte/word valid asserts the cycle after the completing input handshake (1-cycle latency).
- Outputs hold stable while valid & !ready.
- Full throughput is 1 byte/cycle with ready tied high.
- Simultaneous drain and load of an output register in the same cycle is allowed; there is no bubble.
- Reset mid-packet aborts immediately:
  - output valids drop asynchronously;
  - partial assembly is discarded;
  - the next byte is treated as an opcode.
- Length arithmetic is 16-bit unsigned. length = 0xFFFF is legal for ECHO (65531 payload bytes); the count never wraps.

## Test plan
- ECHO, length 7 (EC 00 07 00 41 42 43) → `hdr_valid_o` once; `opcode_o`=EC, `length_o`=7; bytes 41, 42, 43 with `last_o` on 43.
- ADD, length 12, payload 01 00 00 00 02 00 00 00 → words 0x00000001 then 0x00000002 (`last_o`), with `word_ready_i` toggling 1/0 each cycle; no loss, stable hold.
- Unknown opcode 0x55, length 6 + 2 bytes, followed by a valid ECHO length 4 → `err_o` pulse; no outputs for the bad packet; ECHO header decoded, no payload.
- MUL, length 10 → `err_o`; 6 bytes dropped; next packet parsed correctly.
- DIV, length 12, `word_ready_i` held 0 → first word held; `rx_ready_o` drops on the 4th byte of the second word; releasing ready delivers both words.
- Assert `rst_ni` after 2 payload bytes of ADD → all outputs reset values; a following ECHO length 5 packet is decoded correctly.
